// File: rtl/fault_pkg.sv
// Shared types and constants for the residue fault diagnoser and its divider.
package fault_pkg;

  typedef enum logic [1:0] {
    FT_NONE = 2'b00,
    FT_SA0  = 2'b01,
    FT_SA1  = 2'b10,
    FT_FLIP = 2'b11
  } fault_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StMod,
    StCompare,
    StSearch,
    StDone
  } diag_state_e;

  localparam int unsigned NUM_CAND   = 24;
  localparam int unsigned DIV_CYCLES = 8;

endpackage

// File: rtl/seq_mod8.sv
// Restoring divider producing dividend mod divisor, one quotient bit per cycle, MSB first.
// The first step is taken in the load cycle, so valid_o rises DIV_CYCLES-1 edges after load.
module seq_mod8
  import fault_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [DW-1:0] divisor_i,
  input  logic [DW-1:0] dividend_i,
  output logic          busy_o,
  output logic          valid_o,
  output logic [DW-1:0] rem_o
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  logic [DW-1:0]   rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d, valid_q, valid_d;

  logic [DW-1:0] src_rem, src_quo, src_div, step_rem, step_quo;
  logic [DW:0]   trial;
  logic          take;

  always_comb begin
    src_rem  = load_i ? '0 : rem_q;
    src_quo  = load_i ? dividend_i : quo_q;
    src_div  = load_i ? divisor_i : div_q;
    trial    = {src_rem, src_quo[DW-1]};
    take     = trial >= {1'b0, src_div};
    step_rem = take ? DW'(trial - {1'b0, src_div}) : trial[DW-1:0];
    // Dividend bits shift out the top while quotient bits shift in the bottom.
    step_quo = {src_quo[DW-2:0], take};

    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    if (load_i) begin
      rem_d   = step_rem;
      quo_d   = step_quo;
      div_d   = divisor_i;
      cnt_d   = CntW'(DIV_CYCLES - 1);
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign rem_o   = rem_q;

endmodule

// File: rtl/residue_fault_diagnoser.sv
// Checks a received square and residue against B*B and C_obs mod A, then diagnoses a single-bit
// fault. Defining FAULT_DIAG_SEARCH_EN enables the 24-candidate fault-space search.
module residue_fault_diagnoser
  import fault_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned BW   = 4,
  parameter int unsigned NLOC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic [DW-1:0] C_obs,
  input  logic [DW-1:0] Y_obs,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] Y_calc,
  output logic          fault_det,
  output logic          residue_err,
  output logic          diag_valid,
  output logic [2:0]    f_loc,
  output logic [1:0]    f_type
);

  localparam int unsigned LocW = $clog2(NLOC);

  diag_state_e   state_q, state_d;
  logic [DW-1:0] a_q, a_d, c_q, c_d, yo_q, yo_d, m_q, m_d, y_calc_q, y_calc_d;
  logic          fdet_q, fdet_d, rerr_q, rerr_d, dval_q, dval_d, busy_q, busy_d, done_q, done_d;
  logic [LocW-1:0] floc_q, floc_d;
  fault_type_e   ftype_q, ftype_d;

  logic          accept, div_load, div_busy, div_valid;
  logic [DW-1:0] div_rem, y_comp;

  assign accept   = (state_q == StIdle) && start;
  assign div_load = accept && (A != '0);
  // A zero modulus leaves the divider idle and passes C_obs through as the residue.
  assign y_comp   = (a_q == '0) ? c_q : div_rem;

  seq_mod8 #(
    .DW(DW)
  ) u_mod (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (div_load),
    .divisor_i (A),
    .dividend_i(C_obs),
    .busy_o    (div_busy),
    .valid_o   (div_valid),
    .rem_o     (div_rem)
  );

`ifdef FAULT_DIAG_SEARCH_EN
  logic [4:0]      k_q, k_d;
  fault_type_e     cand_type;
  logic [LocW-1:0] cand_loc;
  logic [DW-1:0]   mask, cand;
  logic            cand_hit, k_last;

  // Type is the outer loop (SA0, SA1, FLIP) so a lone flipped bit reports a stuck type.
  always_comb begin
    cand_type = fault_type_e'(k_q[4:3] + 2'd1);
    cand_loc  = k_q[LocW-1:0];
    mask      = DW'(1) << cand_loc;
    case (cand_type)
      FT_SA0:  cand = m_q & ~mask;
      FT_SA1:  cand = m_q | mask;
      default: cand = m_q ^ mask;
    endcase
    cand_hit = (cand == c_q);
    k_last   = (k_q == 5'(NUM_CAND - 1));
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = (A == '0) ? StCompare : StMod;
      StMod:     if (div_valid && !div_busy) state_d = StCompare;
`ifdef FAULT_DIAG_SEARCH_EN
      StCompare: state_d = (c_q == m_q) ? StDone : StSearch;
      StSearch:  if (cand_hit || k_last) state_d = StDone;
`else
      StCompare: state_d = StDone;
`endif
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    c_d      = c_q;
    yo_d     = yo_q;
    m_d      = m_q;
    y_calc_d = y_calc_q;
    fdet_d   = fdet_q;
    rerr_d   = rerr_q;
    dval_d   = dval_q;
    floc_d   = floc_q;
    ftype_d  = ftype_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef FAULT_DIAG_SEARCH_EN
    k_d      = k_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d      = A;
          c_d      = C_obs;
          yo_d     = Y_obs;
          m_d      = DW'(B) * DW'(B);
          y_calc_d = '0;
          fdet_d   = 1'b0;
          rerr_d   = 1'b0;
          dval_d   = 1'b0;
          floc_d   = '0;
          ftype_d  = FT_NONE;
          busy_d   = 1'b1;
        end
      end
      StCompare: begin
        y_calc_d = y_comp;
        fdet_d   = (c_q != m_q);
        rerr_d   = (y_comp != yo_q);
        dval_d   = (c_q == m_q);
`ifdef FAULT_DIAG_SEARCH_EN
        k_d      = '0;
`endif
      end
`ifdef FAULT_DIAG_SEARCH_EN
      StSearch: begin
        if (cand_hit) begin
          dval_d  = 1'b1;
          floc_d  = cand_loc;
          ftype_d = cand_type;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
`endif
      StDone: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      c_q      <= '0;
      yo_q     <= '0;
      m_q      <= '0;
      y_calc_q <= '0;
      fdet_q   <= 1'b0;
      rerr_q   <= 1'b0;
      dval_q   <= 1'b0;
      floc_q   <= '0;
      ftype_q  <= FT_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FAULT_DIAG_SEARCH_EN
      k_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      c_q      <= c_d;
      yo_q     <= yo_d;
      m_q      <= m_d;
      y_calc_q <= y_calc_d;
      fdet_q   <= fdet_d;
      rerr_q   <= rerr_d;
      dval_q   <= dval_d;
      floc_q   <= floc_d;
      ftype_q  <= ftype_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FAULT_DIAG_SEARCH_EN
      k_q      <= k_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Y_calc      = y_calc_q;
  assign fault_det   = fdet_q;
  assign residue_err = rerr_q;
  assign diag_valid  = dval_q;
  assign f_loc       = floc_q;
  assign f_type      = ftype_q;

endmodule

// File: tb/tb_residue_fault_diagnoser.sv
// Table-driven scoreboard bench for residue_fault_diagnoser; expectations track
// FAULT_DIAG_SEARCH_EN so the same bench serves both builds.
module tb_residue_fault_diagnoser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [3:0] B = '0;
  logic [7:0] C_obs = '0;
  logic [7:0] Y_obs = '0;
  logic       busy, done, fault_det, residue_err, diag_valid;
  logic [7:0] Y_calc;
  logic [2:0] f_loc;
  logic [1:0] f_type;

  always #5 clk = ~clk;

  residue_fault_diagnoser #(
    .DW  (8),
    .BW  (4),
    .NLOC(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .C_obs      (C_obs),
    .Y_obs      (Y_obs),
    .busy       (busy),
    .done       (done),
    .Y_calc     (Y_calc),
    .fault_det  (fault_det),
    .residue_err(residue_err),
    .diag_valid (diag_valid),
    .f_loc      (f_loc),
    .f_type     (f_type)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic [7:0] y;
    logic [7:0] y_calc;
    logic       fdet;
    logic       rerr;
    logic       dval;
    logic [2:0] loc;
    logic [1:0] ftype;
    int         lat;
  } vec_t;

  vec_t vecs[9];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Table holds search-enabled results; without the search a detected fault is undiagnosed.
  function automatic vec_t adjust(input vec_t v);
    vec_t r;
    r = v;
`ifndef FAULT_DIAG_SEARCH_EN
    if (r.fdet) begin
      r.dval  = 1'b0;
      r.loc   = '0;
      r.ftype = '0;
      r.lat   = (r.a == 8'd0) ? 2 : 10;
    end
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    vec_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("Y_calc", int'(Y_calc), int'(e.y_calc));
        chk("fault_det", int'(fault_det), int'(e.fdet));
        chk("residue_err", int'(residue_err), int'(e.rerr));
        chk("diag_valid", int'(diag_valid), int'(e.dval));
        chk("f_loc", int'(f_loc), int'(e.loc));
        chk("f_type", int'(f_type), int'(e.ftype));
        chk("latency", cyc - start_cyc, e.lat);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic drive_start(input vec_t v);
    @(negedge clk);
    A     = v.a;
    B     = v.b;
    C_obs = v.c;
    Y_obs = v.y;
    start = 1'b1;
    exp_q.push_back(adjust(v));
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_timeout"}, 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_Y_calc"}, int'(Y_calc), 0);
    chk({name, "_fault_det"}, int'(fault_det), 0);
    chk({name, "_residue_err"}, int'(residue_err), 0);
    chk({name, "_diag_valid"}, int'(diag_valid), 0);
    chk({name, "_f_loc"}, int'(f_loc), 0);
    chk({name, "_f_type"}, int'(f_type), 0);
  endtask

  initial begin
    int dcnt;
    //           a      b     c       y       y_calc fdet  rerr  dval  loc   type  lat
    vecs[0] = '{8'd7,   4'd5, 8'd25,  8'd4,   8'd4,  1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 10};
    vecs[1] = '{8'd7,   4'd5, 8'h1D,  8'd1,   8'd1,  1'b1, 1'b0, 1'b1, 3'd2, 2'd2, 21};
    vecs[2] = '{8'd10,  4'd15, 8'h61, 8'd0,   8'd7,  1'b1, 1'b1, 1'b1, 3'd7, 2'd1, 18};
    vecs[3] = '{8'd5,   4'd3, 8'h0F,  8'd0,   8'd0,  1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 34};
    vecs[4] = '{8'd0,   4'd2, 8'd4,   8'd4,   8'd4,  1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 2};
    vecs[5] = '{8'd255, 4'd15, 8'd225, 8'd225, 8'd225, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 10};
    vecs[6] = '{8'd1,   4'd0, 8'hFF,  8'd0,   8'd0,  1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 34};
    vecs[7] = '{8'd3,   4'd2, 8'd5,   8'd0,   8'd2,  1'b1, 1'b1, 1'b1, 3'd0, 2'd2, 19};
    vecs[8] = '{8'd0,   4'd3, 8'd8,   8'd8,   8'd8,  1'b1, 1'b0, 1'b1, 3'd0, 2'd1, 3};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive_start(vecs[i]);
      wait_drain($sformatf("vec%0d", i));
    end

    // Reset mid-operation: outputs clear on the next edge and the operation never completes.
    drive_start(vecs[3]);
`ifdef FAULT_DIAG_SEARCH_EN
    repeat (14) @(negedge clk);
`else
    repeat (4) @(negedge clk);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    exp_q.delete();
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);

    // A start pulse at cycle 3 of a running operation must not disturb it.
    drive_start(vecs[1]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    A     = vecs[0].a;
    B     = vecs[0].b;
    C_obs = vecs[0].c;
    Y_obs = vecs[0].y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("ignored_start");
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_from_ignored_start", dcnt, 0);

    drive_start(vecs[2]);
    wait_drain("recovery");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
